// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for serial_add_ctrl: operand channel, result channel, status.
// Optional ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, LSB first, registered carry, valid/ready I/O.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_cy;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_nxt;

    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_cy     = (r_a_sh[0] & r_b_sh[0]) |
                      ((r_a_sh[0] ^ r_b_sh[0]) & r_carry);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = bus.in_valid & bus.in_ready;

    // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sum_nxt = w_s;
        end else begin : g_wn
            assign w_sum_nxt = {w_s, r_sum[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_carry <= w_cy;
                    r_sum   <= w_sum_nxt;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf       <= r_carry ^ w_cy;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gated by rst so a request in the reset cycle can never handshake
    assign bus.in_ready  = (r_state == IDLE) & ~rst;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
    assign bus.busy      = (r_state != IDLE);
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
